// File: rtl/ntt_pair_fetch.sv
// Butterfly pair fetcher for one NTT stage: walks pair index k = 0..N/2-1, drives
// both ROM ports, and queues the returned (a, b) coefficients in a 2-entry FIFO.
module ntt_pair_fetch #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    stage,
  output logic [AW-1:0] address1,
  output logic [AW-1:0] address2,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-2:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int KW = AW - 1;
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [2:0] SH_TOP = 3'(KW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Insert a zero at bit log2(h) of k: low bits index within the group, high bits pick the group.
  function automatic logic [AW-1:0] pair_lo_addr(input logic [KW-1:0] k,
                                                 input logic [AW-1:0] h);
    logic [AW-1:0] kx;
    logic [AW-1:0] mask;
    kx   = {1'b0, k};
    mask = h - {{(AW-1){1'b0}}, 1'b1};
    return ((kx & ~mask) << 1'b1) | (kx & mask);
  endfunction

  state_t          state_r, state_s;
  logic [2:0]      stage_r;
  logic [KW-1:0]   k_r;
  logic [KW-1:0]   idx_r;
  logic            issue_r;
  logic            issue_s;
  logic            accept_s;
  logic            done_s;
  logic            done_r;
  logic            busy_r;
  logic [AW-1:0]   half_s;
  logic [AW-1:0]   addr1_s;
  logic [AW-1:0]   addr2_s;
  logic [AW-1:0]   addr1_r;
  logic [AW-1:0]   addr2_r;
  logic            push_s;
  logic            pop_s;
  logic [DW-1:0]   fa_r [2];
  logic [DW-1:0]   fb_r [2];
  logic [KW-1:0]   fk_r [2];
  logic [1:0]      fl_r;
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [1:0]      count_r;

  assign half_s  = {{(AW-1){1'b0}}, 1'b1} << (SH_TOP - stage_r);
  assign addr1_s = pair_lo_addr(k_r, half_s);
  assign addr2_s = addr1_s + half_s;

  assign out_valid = (count_r != 2'd0);
  assign out_a     = fa_r[rd_ptr_r];
  assign out_b     = fb_r[rd_ptr_r];
  assign out_idx   = fk_r[rd_ptr_r];
  assign out_last  = fl_r[rd_ptr_r];
  assign pop_s     = out_valid & out_ready;
  assign push_s    = issue_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Next-state, issue and completion decode.
  always_comb begin
    state_s  = state_r;
    issue_s  = 1'b0;
    accept_s = 1'b0;
    done_s   = 1'b0;
    unique case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Reserve room for the pair in flight so the FIFO can absorb a full stall.
        issue_s = (({1'b0, count_r} + {2'b00, issue_r}) < (3'd2 + {2'b00, pop_s}));
        if (issue_s && (k_r == K_LAST)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && out_last) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // ROM addresses track the pair being issued, otherwise hold the last issued pair.
  always_comb begin
    if (issue_s) begin
      address1 = addr1_s;
      address2 = addr2_s;
    end else begin
      address1 = addr1_r;
      address2 = addr2_r;
    end
  end

  // Control state, pair counter and issue pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      stage_r <= 3'd0;
      k_r     <= '0;
      idx_r   <= '0;
      issue_r <= 1'b0;
      addr1_r <= '0;
      addr2_r <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      issue_r <= issue_s;
      idx_r   <= k_r;
      done_r  <= done_s;
      if (accept_s) begin
        stage_r <= stage;
        k_r     <= '0;
      end else if (issue_s) begin
        k_r     <= k_r + {{(KW-1){1'b0}}, 1'b1};
      end
      if (issue_s) begin
        addr1_r <= addr1_s;
        addr2_r <= addr2_s;
      end
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (done_r) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Two-entry output FIFO; data returning from the ROM lands one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_r[0]  <= '0;
      fa_r[1]  <= '0;
      fb_r[0]  <= '0;
      fb_r[1]  <= '0;
      fk_r[0]  <= '0;
      fk_r[1]  <= '0;
      fl_r     <= 2'b00;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fa_r[wr_ptr_r] <= a;
        fb_r[wr_ptr_r] <= b;
        fk_r[wr_ptr_r] <= idx_r;
        fl_r[wr_ptr_r] <= (idx_r == K_LAST);
        wr_ptr_r       <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      unique case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_pair_fetch.sv
// Randomized scoreboard bench for ntt_pair_fetch against an identity ROM (mem[i] = i).
module tb_ntt_pair_fetch;

  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-2:0] k;
    logic          last;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    stage_in;
  logic [AW-1:0] address1, address2;
  logic [DW-1:0] a, b;
  logic          out_valid, out_ready, out_last, busy, done;
  logic [DW-1:0] out_a, out_b;
  logic [AW-2:0] out_idx;

  pair_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    t0 = 0;
  int    first_valid_cyc = -1;
  int    last_hs_cyc = -1;
  int    hs_cnt = 0;
  int    ready_mode = 0;
  logic  held_v = 1'b0;
  logic [2*DW+AW-2:0] held;

  ntt_pair_fetch #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage_in),
    .address1(address1), .address2(address2), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Identity ROM with a one-cycle registered read on both ports.
  always @(posedge clk) begin
    a <= {{(DW-AW){1'b0}}, address1};
    b <= {{(DW-AW){1'b0}}, address2};
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic pair_t ref_pair(input int s, input int k);
    int h, g, j, a1;
    pair_t p;
    h  = 128 >> s;
    g  = k / h;
    j  = k % h;
    a1 = g * 2 * h + j;
    p.a    = DW'(a1);
    p.b    = DW'(a1 + h);
    p.k    = (AW-1)'(k);
    p.last = (k == 127);
    return p;
  endfunction

  // Consumer handshake pattern.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 99) < 60);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("stall_hold", {out_valid, out_a, out_b, out_idx}, {1'b1, held});
      held_v = out_valid && !out_ready;
      held   = {out_a, out_b, out_idx};
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (out_last) last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_pair", {out_a, out_b, out_idx, out_last}, 64'd0);
        end else begin
          check("pair", {out_a, out_b, out_idx, out_last}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_job(input int s, input bit push_exp);
    @(posedge clk);
    #1;
    stage_in = 3'(s);
    start    = 1'b1;
    t0       = cyc;
    first_valid_cyc = -1;
    if (push_exp)
      for (int k = 0; k < 128; k++) exp_q.push_back(ref_pair(s, k));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output int dcyc);
    bit got;
    got  = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    check(name, 64'(got), 64'd1);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int dcyc;
    int base;
    bit reached;
    rst_n = 1'b0;
    start = 1'b0;
    stage_in = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_addr",  {address1, address2}, 64'd0);
    rst_n = 1'b1;

    // Stage 0 at full throughput: latency and completion timing.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    start_job(0, 1'b1);
    check("run_busy", 64'(busy), 64'd1);
    check("k0_addr", {address1, address2}, {8'd0, 8'd128});
    wait_done(400, "done_s0", dcyc);
    check("first_valid_cyc", 64'(first_valid_cyc - t0), 64'd3);
    check("last_hs_cyc", 64'(last_hs_cyc - t0), 64'd130);
    check("done_cyc", 64'(dcyc - t0), 64'd131);
    check("busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_after", {busy, done}, 64'd0);

    // Extreme and middle stages.
    start_job(7, 1'b1);
    wait_done(400, "done_s7", dcyc);
    start_job(3, 1'b1);
    wait_done(400, "done_s3", dcyc);

    // Random back-pressure with a 10-cycle hard stall.
    for (int r = 0; r < 3; r++) begin
      ready_mode = 1;
      start_job(int'($urandom_range(0, 7)), 1'b1);
      repeat (20) @(posedge clk);
      ready_mode = 2;
      repeat (10) @(posedge clk);
      ready_mode = 1;
      wait_done(3000, "done_rand", dcyc);
    end

    // A second start mid-job must be ignored.
    ready_mode = 0;
    start_job(1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    stage_in = 3'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, "done_restart", dcyc);
    repeat (10) @(negedge clk);
    check("no_extra_job", {out_valid, busy}, 64'd0);

    // Reset in the middle of a job, then a fresh stage-2 job.
    ready_mode = 1;
    start_job(1, 1'b1);
    base = hs_cnt;
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hs_cnt - base >= 61) begin
        reached = 1'b1;
        break;
      end
    end
    check("reach_pair60", 64'(reached), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", {out_valid, out_last, busy, done, out_idx}, 64'd0);
    check("midrst_data", {out_a, out_b}, 64'd0);
    check("midrst_addr", {address1, address2}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    start_job(2, 1'b1);
    wait_done(400, "done_after_rst", dcyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ntt_pair_fetch.md
NTT_PAIR_FETCH -- requirements
Module: ntt_pair_fetch

Interface
REQ-001 SHALL have parameter DW, default 16, meaning coefficient width matching the ROM data port.
REQ-002 SHALL have parameter AW, default 8, meaning ROM address width (N = 2^AW = 256 coefficients).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to fetch all pairs of one NTT stage.
REQ-006 SHALL have port stage, input, 3, stage index 0..7, sampled only when start is accepted.
REQ-007 SHALL have ports address1 and address2, output, AW each, read addresses to the dual-port ROM.
REQ-008 SHALL have ports a and b, input, DW each, ROM read data, valid one cycle after the addresses are presented.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_a and out_b (output, DW each), out_idx (output, AW-1, pair index k), and out_last (output, 1, high on pair 127).
REQ-010 SHALL have ports busy (output, 1, job in progress) and done (output, 1, one-cycle pulse on job completion).

Function
REQ-011 SHALL latch h = 128 >> stage on accepted start; for pair k: g = k >> (7-stage), j = k & (h-1), address1 = g*2h + j, address2 = address1 + h.
REQ-012 SHALL run FSM IDLE -> RUN on start while IDLE; RUN -> DRAIN after issuing pair 127; DRAIN -> IDLE on the handshake of pair 127.
REQ-013 SHALL ignore start while not IDLE; stage is not re-sampled.
REQ-014 SHALL issue one pair per cycle in RUN when fifo_count + inflight - pop < 2, where pop = out_valid & out_ready in that cycle.
REQ-015 SHALL register the issue event one cycle and write {a, b, k, k==127} into a 2-entry FIFO on the following edge; the FIFO SHALL never overflow.
REQ-016 SHALL hold address1/address2 at the last-issued pair when no issue occurs; the values are don't-care outside RUN.
REQ-017 SHALL drive out_valid = FIFO not empty, with out_* from the FIFO head; head data stays stable while out_valid & !out_ready.
REQ-018 SHALL, if push and pop occur together on a non-empty FIFO, perform both with the count unchanged.
REQ-019 SHALL deliver pairs strictly in k order 0..127, each exactly once.
REQ-020 SHALL have a latency of 3 cycles: start sampled at edge E0 -> address for k=0 in cycle 1 -> a/b in cycle 2 -> out_valid in cycle 3.
REQ-021 SHALL sustain 1 pair/cycle with out_ready held high.
REQ-022 SHALL pulse done for one cycle in the cycle after the pair-127 handshake; busy is high from the cycle after start through the done cycle.

Reset
REQ-023 SHALL, on rst_n low (asynchronous), force IDLE, FIFO empty, inflight 0, k 0, out_valid 0, busy 0, done 0, address1/address2 0.
REQ-024 SHALL abandon any job on a reset mid-job and discard ROM data returning after release; the next start begins a fresh job at k=0.

Verification (ROM model mem[i]=i, 1-cycle registered read)
REQ-025 SHALL pass: stage=0, start, out_ready=1 -> pairs (0,128),(1,129)..(127,255); out_valid first in cycle 3; last handshake in cycle 130; done in cycle 131.
REQ-026 SHALL pass: stage=7 -> pair k = (2k, 2k+1); stage=3, k=16 -> (32,48), out_last only on k=127.
REQ-027 SHALL pass: out_ready toggled pseudo-randomly plus held low for 10 cycles -> no loss or duplication, out_a/out_b stable while stalled, FIFO count never exceeds 2.
REQ-028 SHALL pass: start re-pulsed with stage=5 during a stage-1 job -> ignored; the stage-1 sequence completes unchanged.
REQ-029 SHALL pass: rst_n low at pair 60 -> all outputs 0 immediately; a new start with stage=2 yields pair0 = (0,32) with no stale pairs.
